// File: rtl/btn_pkg.sv
// Shared types and default timing constants for pushbutton conditioning logic.
// Defaults assume a 100 MHz system clock.
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      LONG    = 2'd2
   } btn_state_e;

   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;    // 10 ms
   localparam int DEF_LONG_CYCLES     = 100_000_000;  // 1 s

endpackage

// File: rtl/input_sync.sv
// Multi-flop synchroniser for a single asynchronous pin; the only logic that
// may touch the raw pin is the first flop of this chain.
module input_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Pushbutton conditioner: synchronise, debounce, then classify into press,
// release and long-press events. All outputs come straight from flops.
module button_debounce
   import btn_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic long_held
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int LW = $clog2(LONG_CYCLES + 1);
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
   localparam logic [LW-1:0] LONG_SAT  = LW'(LONG_CYCLES);

   logic btn_sync;

   input_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_input_sync (
      .clk (clk),
      .rst (rst),
      .d_i (btn_in),
      .q_o (btn_sync)
   );

   logic [DW-1:0] db_cnt_q, db_cnt_d;
   logic          level_q, level_d;
   logic          rise, fall;

   // Any cycle of agreement with the committed level restarts the count.
   always_comb begin
      db_cnt_d = '0;
      level_d  = level_q;
      rise     = 1'b0;
      fall     = 1'b0;
      if (btn_sync != level_q) begin
         if (db_cnt_q == DB_LAST) begin
            level_d = ~level_q;
            rise    = btn_sync;
            fall    = ~btn_sync;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   btn_state_e    state_q, state_d;
   logic [LW-1:0] long_cnt_q, long_cnt_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          long_q, long_d;
   logic          held_q, held_d;

   // A fall is tested before the long-count terminal so release always wins.
   always_comb begin
      state_d    = state_q;
      long_cnt_d = long_cnt_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      long_d     = 1'b0;
      held_d     = held_q;
      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d    = PRESSED;
               long_cnt_d = '0;
               press_d    = 1'b1;
            end
         end
         PRESSED: begin
            if (fall) begin
               state_d    = IDLE;
               long_cnt_d = '0;
               release_d  = 1'b1;
               held_d     = 1'b0;
            end else if (long_cnt_q == LONG_LAST) begin
               state_d    = LONG;
               long_cnt_d = LONG_SAT;
               long_d     = 1'b1;
               held_d     = 1'b1;
            end else begin
               long_cnt_d = long_cnt_q + 1'b1;
            end
         end
         LONG: begin
            if (fall) begin
               state_d    = IDLE;
               long_cnt_d = '0;
               release_d  = 1'b1;
               held_d     = 1'b0;
            end
         end
         default: begin
            state_d    = IDLE;
            long_cnt_d = '0;
            held_d     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_cnt_q   <= '0;
         level_q    <= 1'b0;
         state_q    <= IDLE;
         long_cnt_q <= '0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         long_q     <= 1'b0;
         held_q     <= 1'b0;
      end else begin
         db_cnt_q   <= db_cnt_d;
         level_q    <= level_d;
         state_q    <= state_d;
         long_cnt_q <= long_cnt_d;
         press_q    <= press_d;
         release_q  <= release_d;
         long_q     <= long_d;
         held_q     <= held_d;
      end
   end

   assign btn_level     = level_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign long_pulse    = long_q;
   assign long_held     = held_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed plus randomised bench for button_debounce against a window-based
// reference model of debounce acceptance and long-press timing.
module tb_button_debounce;

   localparam int SYNC = 2;
   localparam int DB   = 4;
   localparam int LG   = 20;
   localparam int NH   = 16384;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_in = 1'b0;
   logic btn_level, press_pulse, release_pulse, long_pulse, long_held;

   always #5 clk = ~clk;

   button_debounce #(
      .SYNC_STAGES(SYNC),
      .DEBOUNCE_CYCLES(DB),
      .LONG_CYCLES(LG)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .btn_in        (btn_in),
      .btn_level     (btn_level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_pulse    (long_pulse),
      .long_held     (long_held)
   );

   int vectors = 0;
   int miscompares = 0;
   int edge_n = 0;
   int long_seen = 0;

   // Reference model: a level change is accepted on edge k when the
   // synchronised pin disagreed with the level on each of the last DB edges,
   // all of them after the previous acceptance (or reset).
   bit   in_hist [NH];
   int   last_flip = 0;
   int   press_edge = 0;
   bit   m_level = 1'b0;
   bit   m_held = 1'b0;
   logic [4:0] exp_vec = 5'b0;

   wire [4:0] obs = {btn_level, press_pulse, release_pulse, long_pulse, long_held};

   task automatic check_vec(input string tag, input logic [4:0] o, input logic [4:0] e);
      vectors++;
      assert (o === e) else begin
         miscompares++;
         $error("FAIL %s edge=%0d observed=%b expected=%b (lvl,prs,rel,lng,held)", tag, edge_n, o, e);
      end
   endtask

   task automatic check_int(input string tag, input int o, input int e);
      vectors++;
      assert (o === e) else begin
         miscompares++;
         $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, edge_n, o, e);
      end
   endtask

   task automatic model_step(input logic b, input logic r);
      bit flip;
      bit pp, rp, lp;
      if (r) begin
         in_hist[edge_n] = 1'b0;
         m_level   = 1'b0;
         m_held    = 1'b0;
         last_flip = edge_n;
         exp_vec   = 5'b0;
         return;
      end
      in_hist[edge_n] = b;
      flip = 1'b1;
      for (int e = edge_n - DB + 1; e <= edge_n; e++) begin
         if (e <= last_flip) flip = 1'b0;
         else if (in_hist[e - SYNC] == m_level) flip = 1'b0;
      end
      pp = 1'b0; rp = 1'b0; lp = 1'b0;
      if (flip) begin
         last_flip = edge_n;
         if (!m_level) begin
            m_level = 1'b1;
            pp = 1'b1;
            press_edge = edge_n;
         end else begin
            m_level = 1'b0;
            rp = 1'b1;
            m_held = 1'b0;
         end
      end else if (m_level && !m_held && (edge_n - press_edge == LG)) begin
         lp = 1'b1;
         m_held = 1'b1;
      end
      exp_vec = {m_level, pp, rp, lp, m_held};
   endtask

   task automatic tick();
      logic b, r;
      @(posedge clk);
      b = btn_in;
      r = rst;
      edge_n++;
      if (edge_n >= NH) begin
         $display("FAIL history_overflow edge=%0d", edge_n);
         $fatal(1, "history overflow");
      end
      model_step(b, r);
      #1;
      if (long_pulse) long_seen++;
      check_vec("cycle", obs, exp_vec);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // which: 0 press, 1 release, 2 long. Returns edges waited (capped at max).
   task automatic wait_evt(input int which, input int max, output int n);
      logic hit;
      n = 0;
      hit = 1'b0;
      while (!hit && n < max) begin
         tick();
         n++;
         case (which)
            0: hit = press_pulse;
            1: hit = release_pulse;
            default: hit = long_pulse;
         endcase
      end
   endtask

   initial begin
      int n;
      int ls0;

      #2;
      check_vec("reset_state", obs, 5'b0);
      ticks(3);
      rst = 1'b0;
      ticks(5);

      // Clean press
      btn_in = 1'b1;
      wait_evt(0, 30, n);
      check_int("clean_press_latency", n, SYNC + DB);
      ticks(4);
      btn_in = 1'b0;
      wait_evt(1, 30, n);
      check_int("clean_release_latency", n, SYNC + DB);
      ticks(4);

      // Bounce 1,0,1,0 every 2 cycles then hold 1
      for (int i = 0; i < 4; i++) begin
         btn_in = (i % 2 == 0);
         ticks(2);
      end
      btn_in = 1'b1;
      wait_evt(0, 30, n);
      check_int("bounce_press_latency", n, SYNC + DB);

      // Long press from the same held press
      wait_evt(2, 40, n);
      check_int("long_after_press", n, LG);
      ticks(20);
      check_int("long_held_stays", int'(long_held), 1);
      btn_in = 1'b0;
      wait_evt(1, 30, n);
      check_int("long_release_latency", n, SYNC + DB);
      check_int("long_held_cleared", int'(long_held), 0);
      ticks(4);

      // Short press: no long event
      ls0 = long_seen;
      btn_in = 1'b1;
      wait_evt(0, 30, n);
      ticks(10);
      btn_in = 1'b0;
      wait_evt(1, 30, n);
      check_int("short_release_latency", n, SYNC + DB);
      check_int("short_no_long", long_seen - ls0, 0);
      ticks(4);

      // Release accepted exactly on the long-count terminal cycle
      ls0 = long_seen;
      btn_in = 1'b1;
      wait_evt(0, 30, n);
      ticks(LG - SYNC - DB);
      btn_in = 1'b0;
      wait_evt(1, 30, n);
      check_int("collision_release_latency", n, SYNC + DB);
      ticks(3);
      check_int("collision_no_long", long_seen - ls0, 0);

      // Reset while pressed, button held through reset
      btn_in = 1'b1;
      wait_evt(0, 30, n);
      ticks(3);
      rst = 1'b1;
      #1;
      check_vec("async_reset_clears", obs, 5'b0);
      ticks(2);
      rst = 1'b0;
      wait_evt(0, 30, n);
      check_int("press_after_reset", n, SYNC + DB);
      btn_in = 1'b0;
      ticks(10);

      // Randomised bouncy activity, occasional reset
      for (int s = 0; s < 150; s++) begin
         if ($urandom_range(0, 39) == 0) begin
            rst = 1'b1;
            ticks($urandom_range(1, 3));
            rst = 1'b0;
         end
         btn_in = $urandom_range(0, 1);
         if ($urandom_range(0, 4) == 0) ticks($urandom_range(15, 35));
         else ticks($urandom_range(1, 7));
      end
      btn_in = 1'b0;
      ticks(10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
Input-side counterpart to the LED blinker: conditions one raw mechanical pushbutton into a clean, single-clock-domain level plus one-cycle press, release and long-press events. Sits between the board pin and any control logic (e.g. start/stop of the blinker, mode select). The raw input is fully asynchronous and bouncy; all outputs are glitch-free and registered.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchroniser (min 2)
DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz)
LONG_CYCLES, 100_000_000, cycles a committed press must persist to raise the long-press event (1 s at 100 MHz)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
btn_in  input  1  raw button pin, active-high (1 = pressed), asynchronous to clk
btn_level  output  1  debounced button level
press_pulse  output  1  one-cycle strobe on accepted 0->1 transition
release_pulse  output  1  one-cycle strobe on accepted 1->0 transition
long_pulse  output  1  one-cycle strobe when press has lasted LONG_CYCLES
long_held  output  1  high from long_pulse cycle until accepted release

Behaviour:
- Reset (async assert, sync use after deassert): synchroniser flops, counters, state = 0/IDLE; all outputs 0.
- Synchroniser: btn_in through SYNC_STAGES flops -> btn_sync; no other logic touches btn_in.
- Debounce counter width $clog2(DEBOUNCE_CYCLES+1); cleared every cycle btn_sync == btn_level.
- Counter increments each cycle btn_sync != btn_level; when it would reach DEBOUNCE_CYCLES, btn_level flips next edge and counter clears. Any single-cycle agreement in between restarts the count (bounce rejection).
- Latency: clean step on btn_in -> btn_level change after SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- FSM states: IDLE (level 0), PRESSED (level 1, short), LONG (level 1, long reached).
  IDLE -> PRESSED on accepted rise: press_pulse=1 same cycle btn_level goes 1; long counter cleared.
  PRESSED: long counter (width $clog2(LONG_CYCLES+1)) increments each cycle; on reaching LONG_CYCLES -> LONG, long_pulse=1 for that cycle, long_held=1.
  PRESSED or LONG -> IDLE on accepted fall: release_pulse=1 same cycle btn_level goes 0; long_held=0 same cycle; long counter cleared.
  LONG: long counter holds (saturated); no further long_pulse until a new press.
- Pulses are registered, exactly one cycle; press_pulse and release_pulse never coincide; long_pulse and release_pulse never coincide (release accepted first wins; counter stops).
- Release accepted on the exact cycle long count would complete: release wins, no long_pulse.
- Button held through reset: btn_level starts 0, press accepted SYNC_STAGES + DEBOUNCE_CYCLES cycles after rst deassert.
- Reset asserted mid-press or mid-debounce: immediate return to IDLE, outputs 0, no release_pulse emitted.
- No wrap-around: counters clear or saturate before overflow by construction.

Decomposition:
- Package btn_pkg: state enum (IDLE, PRESSED, LONG), default cycle constants for 100 MHz.
- One sub-module: input_sync (parameterised SYNC_STAGES, async-reset flop chain), reused by future pin inputs.
- Debounce counter and FSM stay in button_debounce.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, SYNC_STAGES=2):
- Clean press: btn_in 0->1 at cycle 10, held -> btn_level=1 and press_pulse one cycle at cycle 16; no other pulses.
- Bounce: btn_in toggles 1,0,1,0 each 2 cycles then holds 1 -> single press_pulse exactly 6 cycles after final 0->1; btn_level never glitches.
- Long press: hold 40 cycles after press accepted -> long_pulse one cycle 20 cycles after press_pulse, long_held=1 until release; release -> release_pulse, long_held=0 same cycle.
- Short press: press accepted, release after 10 cycles -> release_pulse 6 cycles after btn_in falls; long_pulse never asserted.
- Release/long collision: timed so fall is accepted on cycle 20 of long count -> release_pulse only, no long_pulse.
- Reset mid-press: rst pulsed while btn_level=1, btn_in held 1 -> outputs 0 immediately, no release_pulse; new press_pulse 6 cycles after rst deassert.
